// File: rtl/weight_column_fetch.sv
// Weight column fetcher: reads one column (WEIGHT_ROWS elements) from the weight
// SRAM per handshake and presents it packed to the MAC stage; owns column sequencing.

module weight_column_fetch_slot #(
  parameter int DATA_WIDTH = 5,
  parameter int ROW_W      = 2,
  parameter int IDX        = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cap_i,
  input  logic [ROW_W-1:0]      row_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                                data_q <= '0;
    else if (cap_i && (row_i == ROW_W'(IDX)))    data_q <= data_i;
  end

  assign q_o = data_q;
endmodule

module weight_column_fetch #(
  parameter int WEIGHT_ROWS          = 4,
  parameter int WEIGHT_COLS          = 3,
  parameter int DATA_WIDTH           = 5,
  parameter int COUNTER_WEIGHT_WIDTH = $clog2(WEIGHT_COLS),
  parameter int ADDR_WIDTH           = $clog2(WEIGHT_ROWS*WEIGHT_COLS)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic [COUNTER_WEIGHT_WIDTH-1:0]   weight_counter_i,
  output logic                              weight_cnt_en_o,
  output logic                              mem_read_en_o,
  output logic [ADDR_WIDTH-1:0]             mem_read_addr_o,
  input  logic [DATA_WIDTH-1:0]             mem_read_data_i,
  output logic [WEIGHT_ROWS*DATA_WIDTH-1:0] col_data_o,
  output logic                              col_valid_o,
  input  logic                              col_ready_i,
  output logic                              busy_o,
  output logic                              done_o
);
  localparam int ROW_W = (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1;
  localparam logic [ROW_W-1:0]                ROW_LAST = ROW_W'(WEIGHT_ROWS-1);
  localparam logic [COUNTER_WEIGHT_WIDTH-1:0] COL_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS-1);

  typedef enum logic [1:0] {IDLE, READ, LAST, VALID} state_e;

  state_e                 state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   rd_vld_q;
  logic [ROW_W-1:0]       rd_row_q;
  logic                   done_q, done_d;
  logic                   rd_en;
  logic                   handshake;
  logic [WEIGHT_ROWS-1:0][DATA_WIDTH-1:0] slot_data;

  assign handshake = (state_q == VALID) && col_ready_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      row_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_row_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      rd_vld_q <= rd_en;
      rd_row_q <= row_q;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rd_en   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = READ;
          row_d   = '0;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (row_q == ROW_LAST) state_d = LAST;
        else                   row_d   = row_q + 1'b1;
      end
      LAST: state_d = VALID;
      VALID: begin
        if (handshake) begin
          if (weight_counter_i == COL_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            row_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data lands one cycle after its read strobe; the registered strobe/row pair
  // steers it into the matching slot, which also covers the LAST-state capture.
  for (genvar r = 0; r < WEIGHT_ROWS; r++) begin : g_slot
    weight_column_fetch_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_W      (ROW_W),
      .IDX        (r)
    ) u_slot (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .cap_i   (rd_vld_q),
      .row_i   (rd_row_q),
      .data_i  (mem_read_data_i),
      .q_o     (slot_data[r])
    );
  end

  assign mem_read_en_o   = rd_en;
  assign mem_read_addr_o = rd_en ? (ADDR_WIDTH'(weight_counter_i) * ADDR_WIDTH'(WEIGHT_ROWS)
                                    + ADDR_WIDTH'(row_q)) : '0;
  assign weight_cnt_en_o = handshake;
  assign col_data_o      = slot_data;
  assign col_valid_o     = (state_q == VALID);
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
endmodule

// File: tb/tb_weight_column_fetch.sv
// Bench for weight_column_fetch: SRAM and column counter models around the DUT,
// expected columns/addresses derived directly from SRAM contents and start column.

module tb_weight_column_fetch;
  localparam int R  = 4;
  localparam int C  = 3;
  localparam int DW = 5;
  localparam int CW = $clog2(C);
  localparam int AW = $clog2(R*C);

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, col_ready = 1'b0;
  logic [CW-1:0] cnt;
  logic cnt_en, rd_en, col_valid, busy, done;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata = '0;
  logic [R*DW-1:0] col_data;
  logic cnt_ld = 1'b0;
  logic [CW-1:0] cnt_ld_val = '0;
  logic [DW-1:0] mem [R*C];

  int tests = 0, failed = 0;

  logic [R*DW-1:0] got_cols[$], exp_cols[$];
  int got_addr[$], exp_addr[$];
  int n_en, n_done, first_vld, viol, stall_viol, en_early, timeout, done_cyc;

  always #5 clk = ~clk;

  weight_column_fetch #(.WEIGHT_ROWS(R), .WEIGHT_COLS(C), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .weight_counter_i(cnt),
    .weight_cnt_en_o(cnt_en), .mem_read_en_o(rd_en), .mem_read_addr_o(addr),
    .mem_read_data_i(rdata), .col_data_o(col_data), .col_valid_o(col_valid),
    .col_ready_i(col_ready), .busy_o(busy), .done_o(done));

  always @(posedge clk) if (rd_en) rdata <= mem[addr];

  always @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (cnt_ld) cnt <= cnt_ld_val;
    else if (cnt_en) cnt <= (cnt == CW'(C-1)) ? '0 : cnt + 1'b1;
  end

  function automatic void build_expect(input int k);
    exp_cols.delete();
    exp_addr.delete();
    for (int c = k; c < C; c++) begin
      logic [R*DW-1:0] v;
      v = '0;
      for (int r = 0; r < R; r++) begin
        v[r*DW +: DW] = mem[c*R + r];
        exp_addr.push_back(c*R + r);
      end
      exp_cols.push_back(v);
    end
  endfunction

  function automatic int col_diffs();
    int n;
    n = 0;
    if (got_cols.size() != exp_cols.size()) return 1000;
    foreach (exp_cols[i]) if (got_cols[i] !== exp_cols[i]) n++;
    return n;
  endfunction

  function automatic int addr_diffs();
    int n;
    n = 0;
    if (got_addr.size() != exp_addr.size()) return 1000;
    foreach (exp_addr[i]) if (got_addr[i] != exp_addr[i]) n++;
    return n;
  endfunction

  // mode 0: ready always 1; 1: random ready; 2: hold ready low stall_len cycles on column stall_col
  task automatic run_pass(input int mode, input int again_cyc, input int stall_col, input int stall_len);
    int hs, stall_left;
    logic v, prev_hold;
    logic [R*DW-1:0] prev_data;
    got_cols.delete(); got_addr.delete();
    n_en = 0; n_done = 0; first_vld = -1; viol = 0; stall_viol = 0; en_early = 0;
    done_cyc = -1; hs = 0; stall_left = stall_len; prev_hold = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == again_cyc);
      #1;
      v = col_valid;
      case (mode)
        0: col_ready = 1'b1;
        1: col_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (v && hs == stall_col && stall_left > 0) begin
            col_ready = 1'b0;
            stall_left--;
          end else col_ready = 1'b1;
        end
      endcase
      #1;
      if (rd_en) got_addr.push_back(int'(addr));
      if (col_valid && first_vld < 0) first_vld = cyc;
      if (cnt_en) begin
        n_en++;
        if (!(col_valid && col_ready)) viol++;
        if (first_vld < 0) en_early++;
      end
      if (col_valid && rd_en) viol++;
      if (prev_hold && (!col_valid || col_data !== prev_data)) stall_viol++;
      if (col_valid && !col_ready && (cnt_en || rd_en)) stall_viol++;
      prev_hold = col_valid && !col_ready;
      prev_data = col_data;
      if (col_valid && col_ready) begin
        got_cols.push_back(col_data);
        hs++;
      end
      if (done) begin
        n_done++;
        if (busy) viol++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0 && cyc >= 1 && !busy) viol++;
      if (done_cyc >= 0 && cyc > done_cyc && (busy || done)) viol++;
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    start = 1'b0;
    col_ready = 1'b0;
    timeout = (done_cyc < 0) ? 1 : 0;
  endtask

  task automatic load_counter(input int k);
    @(negedge clk);
    cnt_ld = 1'b1;
    cnt_ld_val = CW'(k);
    @(negedge clk);
    cnt_ld = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    tests++; if ({cnt_en, rd_en, col_valid, busy, done} !== 5'b0) begin failed++;
      $display("FAIL reset_ctrl got=%b want=00000", {cnt_en, rd_en, col_valid, busy, done}); end
    tests++; if (addr !== '0) begin failed++; $display("FAIL reset_addr got=%0h want=0", addr); end
    tests++; if (col_data !== '0) begin failed++; $display("FAIL reset_col_data got=%0h want=0", col_data); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_full_pass();
    for (int a = 0; a < R*C; a++) mem[a] = DW'(a);
    build_expect(0);
    run_pass(0, -1, 0, 0);
    tests++; if (timeout !== 0) begin failed++; $display("FAIL full_timeout got=%0d want=0", timeout); end
    tests++; if (col_diffs() !== 0) begin failed++; $display("FAIL full_cols diffs=%0d want=0", col_diffs()); end
    tests++; if (addr_diffs() !== 0) begin failed++; $display("FAIL full_addr diffs=%0d want=0", addr_diffs()); end
    tests++; if (first_vld !== R+2) begin failed++; $display("FAIL full_first_valid got=%0d want=%0d", first_vld, R+2); end
    tests++; if (n_en !== C) begin failed++; $display("FAIL full_cnt_en got=%0d want=%0d", n_en, C); end
    tests++; if (n_done !== 1) begin failed++; $display("FAIL full_done got=%0d want=1", n_done); end
    tests++; if (done_cyc !== C*(R+2)+1) begin failed++; $display("FAIL full_done_cyc got=%0d want=%0d", done_cyc, C*(R+2)+1); end
    tests++; if (cnt !== '0) begin failed++; $display("FAIL full_counter_end got=%0d want=0", cnt); end
    tests++; if (viol !== 0) begin failed++; $display("FAIL full_protocol violations=%0d want=0", viol); end
  endtask

  task automatic test_early_ready();
    build_expect(0);
    run_pass(0, -1, 0, 0);
    tests++; if (en_early !== 0) begin failed++; $display("FAIL early_cnt_en got=%0d want=0", en_early); end
    tests++; if (col_diffs() !== 0) begin failed++; $display("FAIL early_cols diffs=%0d want=0", col_diffs()); end
  endtask

  task automatic test_backpressure();
    build_expect(0);
    run_pass(2, -1, 1, 5);
    tests++; if (stall_viol !== 0) begin failed++; $display("FAIL bp_stall violations=%0d want=0", stall_viol); end
    tests++; if (n_en !== C) begin failed++; $display("FAIL bp_cnt_en got=%0d want=%0d", n_en, C); end
    tests++; if (col_diffs() !== 0) begin failed++; $display("FAIL bp_cols diffs=%0d want=0", col_diffs()); end
    tests++; if (done_cyc !== C*(R+2)+1+5) begin failed++; $display("FAIL bp_done_cyc got=%0d want=%0d", done_cyc, C*(R+2)+6); end
    tests++; if (viol !== 0) begin failed++; $display("FAIL bp_protocol violations=%0d want=0", viol); end
  endtask

  task automatic test_start_busy();
    build_expect(0);
    run_pass(0, 3, 0, 0);
    tests++; if (col_diffs() !== 0) begin failed++; $display("FAIL sbusy_cols diffs=%0d want=0", col_diffs()); end
    tests++; if (n_done !== 1) begin failed++; $display("FAIL sbusy_done got=%0d want=1", n_done); end
    tests++; if (viol !== 0) begin failed++; $display("FAIL sbusy_protocol violations=%0d want=0", viol); end
  endtask

  task automatic test_partial_pass();
    load_counter(2);
    build_expect(2);
    run_pass(0, -1, 0, 0);
    tests++; if (addr_diffs() !== 0) begin failed++; $display("FAIL partial_addr diffs=%0d want=0", addr_diffs()); end
    tests++; if (col_diffs() !== 0) begin failed++; $display("FAIL partial_cols diffs=%0d want=0", col_diffs()); end
    tests++; if (done_cyc !== R+3) begin failed++; $display("FAIL partial_done_cyc got=%0d want=%0d", done_cyc, R+3); end
    tests++; if (cnt !== '0) begin failed++; $display("FAIL partial_counter_wrap got=%0d want=0", cnt); end
  endtask

  task automatic test_reset_mid_read();
    for (int a = 0; a < R*C; a++) mem[a] = DW'($urandom_range(0, (1 << DW) - 1));
    load_counter(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    tests++; if (rd_en !== 1'b1) begin failed++; $display("FAIL rst_pre_read got=%b want=1", rd_en); end
    reset = 1'b0;
    #1;
    tests++; if ({cnt_en, rd_en, col_valid, busy, done} !== 5'b0) begin failed++;
      $display("FAIL rst_mid_ctrl got=%b want=00000", {cnt_en, rd_en, col_valid, busy, done}); end
    tests++; if (addr !== '0 || col_data !== '0) begin failed++;
      $display("FAIL rst_mid_data addr=%0h col=%0h want=0", addr, col_data); end
    tests++; if (cnt !== '0) begin failed++; $display("FAIL rst_mid_counter got=%0d want=0", cnt); end
    @(negedge clk);
    reset = 1'b1;
    build_expect(0);
    run_pass(0, -1, 0, 0);
    tests++; if (col_diffs() !== 0) begin failed++; $display("FAIL rst_after_cols diffs=%0d want=0", col_diffs()); end
    tests++; if (n_done !== 1) begin failed++; $display("FAIL rst_after_done got=%0d want=1", n_done); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int k;
      for (int a = 0; a < R*C; a++) mem[a] = DW'($urandom_range(0, (1 << DW) - 1));
      k = $urandom_range(0, C-1);
      load_counter(k);
      build_expect(k);
      run_pass(1, $urandom_range(1, 10), 0, 0);
      tests++; if (col_diffs() !== 0) begin failed++; $display("FAIL rnd%0d_cols diffs=%0d want=0", it, col_diffs()); end
      tests++; if (addr_diffs() !== 0) begin failed++; $display("FAIL rnd%0d_addr diffs=%0d want=0", it, addr_diffs()); end
      tests++; if (n_en !== C-k) begin failed++; $display("FAIL rnd%0d_cnt_en got=%0d want=%0d", it, n_en, C-k); end
      tests++; if (n_done !== 1 || timeout !== 0) begin failed++;
        $display("FAIL rnd%0d_done got=%0d timeout=%0d want=1/0", it, n_done, timeout); end
      tests++; if (viol + stall_viol !== 0) begin failed++;
        $display("FAIL rnd%0d_protocol violations=%0d want=0", it, viol + stall_viol); end
      tests++; if (cnt !== '0) begin failed++; $display("FAIL rnd%0d_counter got=%0d want=0", it, cnt); end
    end
  endtask

  initial begin
    for (int a = 0; a < R*C; a++) mem[a] = '0;
    test_reset();
    test_full_pass();
    test_early_ready();
    test_backpressure();
    test_start_busy();
    test_partial_pass();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
